// File: rtl/usb_spi_target.sv
// ---------------------------------------------------------------------------
// usb_spi_target
//
// SPI mode-0 target port running in the clk_48mhz domain. An external SPI
// host clocks bytes in on MOSI and out on MISO. Received bytes are presented
// on a valid/ready output stream. Transmit bytes are pulled from a
// valid/ready input stream at each byte boundary. When no transmit byte is
// available, FILL_BYTE is sent instead.
//
// Ports:
//   clk_48mhz    in   system clock, all state lives here
//   reset_n      in   asynchronous active-low reset
//   spi_csel     in   chip select, active low
//   spi_clk      in   SCLK, idle low
//   spi_mosi     in   host-to-target data, MSB first
//   spi_miso     out  target-to-host data, MSB first
//   spi_miso_oe  out  MISO output enable, high while selected
//   in_data      in   next byte to transmit
//   in_valid     in   in_data is valid
//   in_ready     out  one-cycle load strobe (byte taken when in_valid too)
//   out_data     out  received byte
//   out_valid    out  out_data valid, held until accepted
//   out_ready    in   consumer accepts out_data
//   rx_overrun   out  sticky: received byte dropped (status build only)
//   tx_underrun  out  sticky: fill byte sent (status build only)
//
// Build option:
//   USB_SPI_TARGET_STATUS_EN - when defined, rx_overrun and tx_underrun are
//   sticky flags that clear at each CS fall. When undefined, both are tied
//   low and no status flops exist.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module usb_spi_target #(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       spi_csel,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       rx_overrun,
    output logic       tx_underrun
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;

    logic cs_prev;
    logic sclk_prev;
    logic mosi_d;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;

    logic       active;
    logic       byte_done;
    logic       load_point;
    logic [7:0] rx_byte;
    logic [7:0] tx_next;

    // Input synchronisers. CS resets to deselected and SCLK to its idle
    // level, so leaving reset never looks like a pin edge.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_csel};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Edge detection. The edge flags are registered. mosi_d is delayed by
    // the same stage, so when sclk_rise is high, mosi_d holds the MOSI level
    // that was present at that SCLK rise.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            mosi_d    <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
            mosi_d    <= mosi_s;
            cs_fall   <= cs_prev & ~cs_s;
            cs_rise   <= ~cs_prev & cs_s;
            sclk_rise <= ~sclk_prev & sclk_s;
            sclk_fall <= sclk_prev & ~sclk_s;
        end
    end

    assign active     = (state == ST_ACTIVE);
    // A CS rise seen in the same cycle as the 8th SCLK rise aborts the byte.
    assign byte_done  = active & sclk_rise & ~cs_rise & (bit_cnt == 3'd7);
    assign load_point = (cs_fall & ~cs_rise) | byte_done;
    assign rx_byte    = {rx_shift[6:0], mosi_d};
    assign tx_next    = in_valid ? in_data : FILL_BYTE;

    assign in_ready    = load_point;
    assign spi_miso_oe = active;

    // Transfer state machine and the shift registers.
    // At a CS-fall load, bit 7 goes straight to MISO and the register keeps
    // the remaining bits pre-shifted. At an 8th-rise load, the whole byte is
    // stored and bit 7 is output on the next SCLK fall. Both cases then use
    // the same "output tx_shift[7] and shift left" step on every SCLK fall.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            spi_miso <= 1'b0;
        end else if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            spi_miso <= 1'b0;
        end else if (cs_fall) begin
            state    <= ST_ACTIVE;
            bit_cnt  <= 3'd0;
            spi_miso <= tx_next[7];
            tx_shift <= {tx_next[6:0], 1'b0};
        end else if (active) begin
            if (sclk_rise) begin
                rx_shift <= rx_byte;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    tx_shift <= tx_next;
                end
            end else if (sclk_fall) begin
                spi_miso <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // Output stream register. A completed byte is accepted only when the
    // holding register is empty or is being emptied in the same cycle.
    // Otherwise the new byte is dropped.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else if (byte_done && (!out_valid || out_ready)) begin
            out_data  <= rx_byte;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef USB_SPI_TARGET_STATUS_EN
    logic rx_overrun_q;
    logic tx_underrun_q;

    // Sticky status flags, cleared at the start of each transaction.
    // A CS-fall load with no data clears and then sets tx_underrun in the
    // same cycle. The later assignment (set) wins, so that transaction
    // still reports the underrun.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            if (cs_fall) begin
                rx_overrun_q  <= 1'b0;
                tx_underrun_q <= 1'b0;
            end
            if (byte_done && out_valid && !out_ready) begin
                rx_overrun_q <= 1'b1;
            end
            if (load_point && !in_valid) begin
                tx_underrun_q <= 1'b1;
            end
        end
    end

    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
`else
    assign rx_overrun  = 1'b0;
    assign tx_underrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_spi_target.sv
// ---------------------------------------------------------------------------
// tb_usb_spi_target
//
// Self-checking bench for usb_spi_target. A bench-side SPI host drives the
// pins with SCLK half-periods of HALF clocks. Received bytes the host expects
// are queued in rx_exp. They are popped and compared when the output stream
// handshakes. Transmit bytes are queued in tx_src and fed through the
// in_valid/in_ready stream. The expected status flag values follow
// USB_SPI_TARGET_STATUS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_usb_spi_target;

    localparam int HALF = 8;
`ifdef USB_SPI_TARGET_STATUS_EN
    localparam logic STATUS = 1'b1;
`else
    localparam logic STATUS = 1'b0;
`endif

    logic       clk_48mhz = 1'b0;
    logic       reset_n;
    logic       spi_csel;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       rx_overrun;
    logic       tx_underrun;

    int checkCount   = 0;
    int failCount    = 0;
    int readyPulses  = 0;
    bit takePending  = 1'b0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_src[$];

    usb_spi_target dut (
        .clk_48mhz   (clk_48mhz),
        .reset_n     (reset_n),
        .spi_csel    (spi_csel),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    // Output consumer: a handshake seen here completes at the next rising
    // edge, so the byte is checked against the scoreboard now.
    always @(negedge clk_48mhz) begin
        #1;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (rx_exp.size() == 0) begin
                checkOutput("rx_queue_nonempty", rx_exp.size(), 1);
            end else begin
                checkOutput("rx_byte", {24'h0, out_data}, {24'h0, rx_exp.pop_front()});
            end
        end
    end

    // Counts load strobes. Each strobe lasts one cycle.
    always @(negedge clk_48mhz) begin
        #1;
        if (in_ready === 1'b1) readyPulses++;
    end

    // Transmit feeder: presents the head of tx_src. A byte taken at a strobe
    // is removed only after the rising edge that captured it.
    always @(negedge clk_48mhz) begin
        logic [7:0] tmp;
        #1;
        if (takePending) begin
            tmp = tx_src.pop_front();
            takePending = 1'b0;
        end else if (in_valid && in_ready) begin
            takePending = 1'b1;
        end
        if (!takePending && !in_ready) begin
            in_valid = (tx_src.size() > 0);
            in_data  = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
        end
    end

    task automatic spiSelect();
        spi_csel = 1'b0;
        waitCycles(HALF);
    endtask

    task automatic spiDeselect();
        waitCycles(HALF);
        spi_csel = 1'b1;
        waitCycles(HALF);
    endtask

    task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            waitCycles(HALF);
            rx[7-i] = spi_miso;
            spi_clk = 1'b1;
            waitCycles(HALF);
            spi_clk = 1'b0;
        end
    endtask

    // One full byte inside an open transaction.
    task automatic applyStimulus(input logic [7:0] mosi_byte,
                                 input logic [7:0] miso_exp, input bit expect_rx);
        logic [7:0] got;
        if (expect_rx) rx_exp.push_back(mosi_byte);
        spiBits(mosi_byte, 8, got);
        checkOutput("miso_byte", {24'h0, got}, {24'h0, miso_exp});
    endtask

    task automatic drainCheck(input string tag);
        for (int i = 0; i < 64 && rx_exp.size() != 0; i++) waitCycles(1);
        checkOutput(tag, rx_exp.size(), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_miso"},      spi_miso,    0);
        checkOutput({tag, "_miso_oe"},   spi_miso_oe, 0);
        checkOutput({tag, "_in_ready"},  in_ready,    0);
        checkOutput({tag, "_out_data"},  out_data,    0);
        checkOutput({tag, "_out_valid"}, out_valid,   0);
        checkOutput({tag, "_overrun"},   rx_overrun,  0);
        checkOutput({tag, "_underrun"},  tx_underrun, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] dummy;
        reset_n   = 1'b1;
        spi_csel  = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3 reset_n = 1'b0;
        waitCycles(3);
        checkResetState("reset");
        reset_n = 1'b1;
        waitCycles(4);

        $display("[TB] single byte A5 in, 3C out");
        tx_src.push_back(8'h3C);
        waitCycles(3);
        readyPulses = 0;
        spiSelect();
        checkOutput("ready_at_cs_fall", readyPulses, 1);
        checkOutput("miso_oe_selected", spi_miso_oe, 1);
        applyStimulus(8'hA5, 8'h3C, 1'b1);
        spiDeselect();
        drainCheck("rx_drain_single");
        checkOutput("miso_oe_deselected", spi_miso_oe, 0);
        checkOutput("tx_src_consumed", tx_src.size(), 0);

        $display("[TB] four byte burst with no transmit data");
        spiSelect();
        for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 8'hFF, 1'b1);
        spiDeselect();
        drainCheck("rx_drain_burst");
        checkOutput("underrun_burst", tx_underrun, STATUS);

        $display("[TB] overrun with consumer stalled");
        out_ready = 1'b0;
        spiSelect();
        applyStimulus(8'h11, 8'hFF, 1'b1);
        applyStimulus(8'h22, 8'hFF, 1'b0);
        spiDeselect();
        checkOutput("overrun_out_valid", out_valid, 1);
        checkOutput("overrun_out_data", out_data, 8'h11);
        checkOutput("overrun_flag", rx_overrun, STATUS);
        out_ready = 1'b1;
        drainCheck("rx_drain_overrun");
        checkOutput("overrun_valid_cleared", out_valid, 0);
        spiSelect();
        checkOutput("overrun_cleared_at_cs_fall", rx_overrun, 0);
        checkOutput("underrun_at_empty_cs_fall", tx_underrun, STATUS);
        spiDeselect();

        $display("[TB] aborted byte after five SCLK edges");
        spiSelect();
        spiBits(8'hE7, 5, dummy);
        spiDeselect();
        waitCycles(HALF);
        checkOutput("partial_no_valid", out_valid, 0);
        spiSelect();
        applyStimulus(8'h5A, 8'hFF, 1'b1);
        spiDeselect();
        drainCheck("rx_drain_partial");

        $display("[TB] reset pulsed mid-byte");
        spiSelect();
        spiBits(8'h81, 4, dummy);
        reset_n  = 1'b0;
        spi_csel = 1'b1;
        waitCycles(1);
        checkResetState("midreset");
        waitCycles(3);
        reset_n = 1'b1;
        waitCycles(4);
        tx_src.push_back(8'h96);
        waitCycles(3);
        spiSelect();
        applyStimulus(8'hC3, 8'h96, 1'b1);
        spiDeselect();
        drainCheck("rx_drain_after_reset");
        checkOutput("tx_src_after_reset", tx_src.size(), 0);
        checkOutput("overrun_final", rx_overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
